gauss_dotprod_pipe: RTL and testbench

Pipelined, parametrised Gaussian kernel dot-product for the separable convolution datapath. Accepts one window of TAPS pixels plus a per-window sigma select, multiplies by a normalised symmetric coefficient row, and returns one rounded pixel. It sits between the line-buffer window extractor and the output pixel stream, uses valid/ready on both sides, and sustains one window per clock when not back-pressured.

---
 rtl/gauss_pkg.sv | 78 +++++++
 rtl/gauss_coef_rom.sv | 25 ++
 rtl/gauss_dotprod_pipe.sv | 90 +++++++++
 tb/tb_gauss_dotprod_pipe.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/gauss_pkg.sv
// gauss_pkg: Gaussian coefficient tables for every odd window 3..15, the row-sum check,
// the accumulator width helper and the sigma select type.
package gauss_pkg;

    localparam int GAUSS_COEF_W = 12;
    localparam int GAUSS_NSIZE  = 7;
    localparam int GAUSS_NSIG   = 8;
    localparam int GAUSS_HMAX   = 8;

    typedef logic [2:0] sigma_t;
    typedef logic [GAUSS_NSIZE-1:0][GAUSS_NSIG-1:0][GAUSS_HMAX-1:0][GAUSS_COEF_W:0] coef_tab_t;

    function automatic int acc_width(input int data_w, input int coef_w);
        return data_w + coef_w + 1;
    endfunction

    // Q16 of exp(-1/(2*sigma^2)) for sigma 0.5, 0.75, 1, 1.5, 2, 3, 4; row 0 is the identity
    function automatic longint decay_q16(input int s);
        return longint'(s == 1 ? 8869 : s == 2 ? 26943 : s == 3 ? 39750 : s == 4 ? 52476 :
                        s == 5 ? 57835 : s == 6 ? 61995 : s == 7 ? 63520 : 0);
    endfunction

    // r^(d*d) in Q16, built from odd powers so no real arithmetic is needed
    function automatic longint weight_q16(input int s, input int d);
        longint r, r2, step, g;
        r = decay_q16(s);
        r2 = (r * r) >> 16;
        step = r;
        g = longint'(65536);
        for (int i = 0; i < d; i++) begin
            g = (g * step) >> 16;
            step = (step * r2) >> 16;
        end
        return g;
    endfunction

    // Outer taps are floored; the centre absorbs the remainder so each row sums to 2^COEF_W exactly
    function automatic coef_tab_t build_tab();
        coef_tab_t t;
        longint tot, side, w, c;
        t = '0;
        for (int z = 0; z < GAUSS_NSIZE; z++) begin
            for (int s = 0; s < GAUSS_NSIG; s++) begin
                tot = longint'(0);
                side = longint'(0);
                for (int d = 0; d <= z + 1; d++) begin
                    w = weight_q16(s, d);
                    tot = d == 0 ? tot + w : tot + w + w;
                end
                for (int d = 1; d <= z + 1; d++) begin
                    c = (weight_q16(s, d) << GAUSS_COEF_W) / tot;
                    t[z][s][z + 1 - d] = (GAUSS_COEF_W + 1)'(c);
                    side = side + c + c;
                end
                t[z][s][z + 1] = (GAUSS_COEF_W + 1)'((longint'(1) << GAUSS_COEF_W) - side);
            end
        end
        return t;
    endfunction

    function automatic bit row_sums_ok(input coef_tab_t t);
        bit ok;
        longint sum;
        ok = 1'b1;
        for (int z = 0; z < GAUSS_NSIZE; z++) begin
            for (int s = 0; s < GAUSS_NSIG; s++) begin
                sum = longint'(t[z][s][z + 1]);
                for (int k = 0; k <= z; k++) sum = sum + longint'(t[z][s][k]) + longint'(t[z][s][k]);
                ok = ok && (sum == (longint'(1) << GAUSS_COEF_W));
            end
        end
        return ok;
    endfunction

    localparam coef_tab_t GAUSS_TAB    = build_tab();
    localparam bit        GAUSS_TAB_OK = row_sums_ok(GAUSS_TAB);

endpackage

// File: rtl/gauss_coef_rom.sv
// gauss_coef_rom: combinational half-row lookup; coef[k] weights pixel k and its mirror,
// coef[TAPS/2] weights the centre pixel.
module gauss_coef_rom
    import gauss_pkg::*;
#(
    parameter int TAPS    = 11,
    parameter int COEF_W  = 12,
    parameter int SIGMA_W = 3
) (
    input  logic [SIGMA_W-1:0] sigma,
    output logic [COEF_W:0]    coef [(TAPS+1)/2]
);

    localparam int Z = TAPS / 2 - 1;

    sigma_t sel;

    assign sel = sigma_t'(sigma);

    // Tables are stored at the base fraction width; wider fractions scale exactly by shifting
    for (genvar k = 0; k < (TAPS + 1) / 2; k++) begin : g_coef
        assign coef[k] = (COEF_W + 1)'(GAUSS_TAB[Z][sel][k]) << (COEF_W - GAUSS_COEF_W);
    end

endmodule

// File: rtl/gauss_dotprod_pipe.sv
// gauss_dotprod_pipe: four-stage Gaussian window dot product with valid/ready and a global stall.
// Build option GAUSS_DOTPROD_ROUND_EN selects round-half-up; otherwise the result is truncated.
module gauss_dotprod_pipe
    import gauss_pkg::*;
#(
    parameter int TAPS    = 11,
    parameter int DATA_W  = 8,
    parameter int COEF_W  = 12,
    parameter int SIGMA_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SIGMA_W-1:0] in_sigma,
    input  logic [DATA_W-1:0]  in_data [TAPS],
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data
);

    localparam int H     = TAPS / 2;
    localparam int ACC_W = acc_width(DATA_W, COEF_W);
`ifdef GAUSS_DOTPROD_ROUND_EN
    localparam logic [ACC_W-1:0] RND = ACC_W'(1) << (COEF_W - 1);
`else
    localparam logic [ACC_W-1:0] RND = '0;
`endif

    if (TAPS < 3 || TAPS > 15 || TAPS % 2 == 0 || SIGMA_W < 1 || SIGMA_W > 3 ||
        COEF_W < GAUSS_COEF_W || !GAUSS_TAB_OK) begin : g_bad_cfg
        $error("gauss_dotprod_pipe: unsupported parameters or coefficient rows not normalised");
    end

    logic                    en;
    logic                    v1, v2, v3;
    logic [DATA_W-1:0]       d1 [TAPS];
    logic [SIGMA_W-1:0]      s1;
    logic [DATA_W:0]         p2 [H+1];
    logic [COEF_W:0]         c2 [H+1];
    logic [COEF_W:0]         rom_c [H+1];
    logic [ACC_W-1:0]        m3 [H+1];
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-COEF_W-1:0] q;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    gauss_coef_rom #(.TAPS(TAPS), .COEF_W(COEF_W), .SIGMA_W(SIGMA_W)) u_rom (
        .sigma(s1),
        .coef (rom_c)
    );

    always_comb begin
        acc = RND;
        for (int k = 0; k <= H; k++) acc = acc + m3[k];
        q = acc[ACC_W-1:COEF_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            s1        <= '0;
            for (int k = 0; k < TAPS; k++) d1[k] <= '0;
            for (int k = 0; k <= H; k++) begin
                p2[k] <= '0;
                c2[k] <= '0;
                m3[k] <= '0;
            end
        end else if (en) begin
            v1 <= in_valid;
            d1 <= in_data;
            s1 <= in_sigma;
            v2 <= v1;
            c2 <= rom_c;
            for (int k = 0; k < H; k++) p2[k] <= (DATA_W + 1)'(d1[k]) + (DATA_W + 1)'(d1[TAPS-1-k]);
            p2[H] <= (DATA_W + 1)'(d1[H]);
            v3 <= v2;
            for (int k = 0; k <= H; k++) m3[k] <= ACC_W'(p2[k]) * ACC_W'(c2[k]);
            out_valid <= v3;
            // Unreachable with normalised rows, kept as a guard against table edits
            out_data <= q[DATA_W] ? '1 : q[DATA_W-1:0];
        end
    end

endmodule

// File: tb/tb_gauss_dotprod_pipe.sv
// tb_gauss_dotprod_pipe: directed and random streams against a per-tap golden model via a scoreboard.
module tb_gauss_dotprod_pipe;
    import gauss_pkg::*;

    localparam int TAPS    = 11;
    localparam int DATA_W  = 8;
    localparam int COEF_W  = 12;
    localparam int SIGMA_W = 3;
`ifdef GAUSS_DOTPROD_ROUND_EN
    localparam longint RND = longint'(1) << (COEF_W - 1);
`else
    localparam longint RND = longint'(0);
`endif

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [SIGMA_W-1:0] in_sigma;
    logic [DATA_W-1:0]  in_data [TAPS];
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [DATA_W-1:0]  out_data;

    exp_t       q[$];
    logic [7:0] outs[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         bp_en = 1'b0;
    bit         lat_chk = 1'b0;
    bit         held_v = 1'b0;
    logic [7:0] held_d;

    gauss_dotprod_pipe #(.TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .SIGMA_W(SIGMA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sigma (in_sigma),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Direct per-tap sum, independent of the pre-add structure
    function automatic logic [7:0] model(input logic [7:0] w [TAPS], input int s);
        longint acc;
        acc = RND;
        for (int i = 0; i < TAPS; i++)
            acc += longint'(w[i]) * longint'(GAUSS_TAB[TAPS/2-1][s][i <= TAPS/2 ? i : TAPS-1-i]);
        acc = acc >>> COEF_W;
        return acc > 255 ? 8'hff : acc[7:0];
    endfunction

    task automatic send(input logic [7:0] w [TAPS], input int s);
        bit done;
        done = 1'b0;
        in_data  = w;
        in_sigma = SIGMA_W'(s);
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back('{model(w, s), cyc + 1});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        chk("send_accept", 32'(done), 1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && q.size() > 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) held_v = 1'b0;
        else begin
            exp_t e;
            chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
            if (held_v) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_data", out_data, held_d);
            end
            if (out_valid && out_ready) begin
                chk("unexpected_out", 32'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("out_data", out_data, e.data);
                    if (lat_chk) chk("latency", cyc, e.cyc + 3);
                    outs.push_back(out_data);
                end
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
        end
    end

    initial begin
        logic [7:0] w [TAPS];
        logic [7:0] win0 [TAPS];
        win0 = '{8'h0c, 8'hc6, 8'h1e, 8'h8e, 8'hac, 8'he1, 8'he3, 8'hdc, 8'hf6, 8'h81, 8'h86};
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sigma = '0;
        foreach (in_data[i]) in_data[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_out_data", out_data, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 1);

        lat_chk = 1'b1;
        outs.delete();
        foreach (w[i]) w[i] = 8'hff;
        for (int s = 0; s < 8; s++) send(w, s);
        drain(100);
        chk("ff_count", outs.size(), 8);
        foreach (outs[i]) chk("ff_value", outs[i], 8'hff);

        outs.delete();
        foreach (w[i]) w[i] = 8'h7f;
        for (int s = 0; s < 8; s++) send(w, s);
        drain(100);
        chk("7f_count", outs.size(), 8);
        foreach (outs[i]) chk("7f_value", outs[i], 8'h7f);

        outs.delete();
        foreach (w[i]) w[i] = 8'h00;
        w[TAPS/2] = 8'hff;
        for (int s = 0; s < 8; s++) send(w, s);
        drain(100);
        chk("impulse_count", outs.size(), 8);
        chk("impulse_sigma0", outs[0], 8'hff);
        for (int i = 1; i < outs.size(); i++) chk("impulse_nonincreasing", 32'(outs[i] <= outs[i-1]), 1);

        outs.delete();
        for (int s = 0; s < 8; s++) send(win0, s);
        drain(100);
        chk("window_count", outs.size(), 8);
        chk("window_sigma0", outs[0], 8'he1);

        lat_chk = 1'b0;
        bp_en = 1'b1;
        outs.delete();
        for (int n = 0; n < 1000; n++) begin
            foreach (w[i]) w[i] = 8'($urandom);
            send(w, $urandom_range(0, 7));
        end
        drain(20000);
        chk("random_count", outs.size(), 1000);
        bp_en = 1'b0;
        @(posedge clk);
        #1;

        outs.delete();
        for (int n = 0; n < 3; n++) send(win0, n + 1);
        rst_n = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("midreset_out_valid", 32'(out_valid), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_in_ready", 32'(in_ready), 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("midreset_no_output", 32'(out_valid), 0);
        end
        @(posedge clk);
        #1;
        send(win0, 4);
        drain(100);
        chk("post_reset_count", outs.size(), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
